slc3_mem_loader: RTL and testbench
==================================

# slc3_mem_loader

Memory front-end that sits directly downstream of the SLC-3 core's memory port (MAR-driven address, OE/WE strobes, MDR write data) and owns the single port of the on-chip program RAM. After every reset it copies a program image from a synchronous init ROM into RAM while holding the core in reset. It then hands the RAM port to the core and returns registered read data to the core's Mem2IO path.

## Interface
Parameters:
- DEPTH, 256: number of image words copied from ROM to RAM addresses 0..DEPTH-1; must be a power of two, 2..65536.
- ROM_AW, $clog2(DEPTH): ROM address width.

Ports:
- Clk  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- cpu_addr  in  16  core memory address.
- cpu_oe  in  1  core read strobe, active-high.
- cpu_we  in  1  core write strobe, active-high.
- cpu_wdata  in  16  core write data.
- cpu_rdata  out  16  read data to core, registered.
- cpu_hold  out  1  high holds core in reset; tie to the core's Reset input, OR'd with the board reset.
- init_done  out  1  high once the image copy has completed.
- rom_addr  out  ROM_AW  init ROM address; ROM has 1-cycle registered read.
- rom_data  in  16  init ROM data.
- ram_addr  out  16  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  16  RAM read data; 1-cycle registered read.

## Operation
- States: S_PRIME, S_COPY, S_RUN.
- Reset, from any state and at any cycle including mid-copy: go to S_PRIME. Clear the counter cnt to 0 and cpu_rdata to 0x0000. Drive cpu_hold=1 and init_done=0. RAM contents are left untouched and the copy restarts from address 0.
- S_PRIME, 1 cycle:
  - rom_addr=0, ram_we=0.
  - Next state S_COPY with cnt=0.
- S_COPY, DEPTH cycles:
  - ram_we=1, ram_addr=cnt zero-extended, ram_wdata=rom_data.
  - rom_addr=cnt+1, truncated to ROM_AW bits; it wraps to 0 on the last word and that value is harmless.
  - cnt increments each cycle. When cnt==DEPTH-1, the next state is S_RUN.
- S_COPY is never re-entered except through Reset.
- In S_PRIME and S_COPY, all cpu_* inputs are ignored: core writes are dropped and cpu_rdata holds 0x0000.
- S_RUN:
  - cpu_hold=0, init_done=1.
  - ram_addr=cpu_addr, unmodified; addresses >= DEPTH pass through to RAM.
  - ram_we=cpu_we, ram_wdata=cpu_wdata. rom_addr holds 0.
  - rd_pend <= cpu_oe & ~cpu_we. When rd_pend is set, cpu_rdata <= ram_rdata; otherwise cpu_rdata holds.
- Simultaneous cpu_oe and cpu_we: the write is performed, no read is registered, and cpu_rdata holds its previous value.
- No arithmetic beyond cnt+1; cnt is ROM_AW+1 bits wide, so there is no overflow at DEPTH=65536.

## Timing
- Reset asserted on edge E0: S_PRIME during the cycle after E0. Copy writes occupy cycles 1..DEPTH. S_RUN is reached, with init_done=1 and cpu_hold=0, at cycle DEPTH+1.
- Load time: DEPTH+1 cycles after Reset deasserts.
- Copy writes are one per cycle, in ascending address order, with no gaps.
- Read latency: cpu_oe and cpu_addr presented in cycle N give valid cpu_rdata in cycle N+2, held until the next registered read. The ISDU's memory-wait states must span at least 2 cycles.
- Write: a write presented in cycle N is committed to RAM at the edge ending cycle N.
- Reset outputs: cpu_rdata=0x0000, cpu_hold=1, init_done=0, ram_we=0, rom_addr=0, ram_addr=0, ram_wdata=0.

## Structure
- Shared package slc3_mem_pkg holds:
  - the state enum (S_PRIME, S_COPY, S_RUN);
  - WORD_W=16;
  - DEPTH_DEFAULT=256.
- No sub-module: the copy counter, rd_pend flag and cpu_rdata register stay inline in one flat FSM.
- RAM and ROM are external, instantiated at the top level.

## Test plan
- DEPTH=4, ROM={0x1234,0x5678,0x9ABC,0xDEF0}, pulse Reset -> ram_we=1 with (addr,data)=(0,0x1234),(1,0x5678),(2,0x9ABC),(3,0xDEF0) on cycles 1..4; init_done rises and cpu_hold falls at cycle 5.
- After load, cpu_oe=1 with cpu_addr=0x0002 for 1 cycle -> cpu_rdata=0x9ABC exactly 2 cycles later and held afterwards.
- After load, cpu_we=1, cpu_addr=0x0001, cpu_wdata=0xBEEF, then read 0x0001 -> cpu_rdata=0xBEEF. An address of 0x0100 passes through unmodified to ram_addr.
- Core drives cpu_we=1, cpu_addr=0x0000, cpu_wdata=0xFFFF during S_COPY -> ram_wdata comes from the ROM only; RAM[0] remains 0x1234 after load.
- Reset asserted at copy cycle 2 -> cpu_hold=1, init_done=0, copy restarts at address 0; full image is correct at cycle 5 after the second reset.
- In S_RUN, cpu_oe=1 and cpu_we=1 together with addr 0x0003, data 0x0042 -> RAM[3]=0x0042 and cpu_rdata unchanged.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared definitions for the SLC-3 memory front-end: word width, default image depth, FSM states.
package slc3_mem_pkg;

   localparam int WORD_W        = 16;
   localparam int DEPTH_DEFAULT = 256;

   typedef enum logic [1:0] {
      S_PRIME,
      S_COPY,
      S_RUN
   } state_t;

endpackage

// File: rtl/slc3_mem_loader.sv
// SLC-3 memory front-end: copies the init ROM image into program RAM after every reset,
// then hands the single RAM port to the core and registers read data for Mem2IO.
module slc3_mem_loader
   import slc3_mem_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ROM_AW = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [WORD_W-1:0] cpu_addr,
   input  logic              cpu_oe,
   input  logic              cpu_we,
   input  logic [WORD_W-1:0] cpu_wdata,
   output logic [WORD_W-1:0] cpu_rdata,
   output logic              cpu_hold,
   output logic              init_done,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [WORD_W-1:0] rom_data,
   output logic [WORD_W-1:0] ram_addr,
   output logic [WORD_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [WORD_W-1:0] ram_rdata
);

   // One spare bit keeps DEPTH itself representable, so DEPTH=65536 cannot overflow.
   localparam int CNT_W = ROM_AW + 1;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             rd_pend;
   logic             last_word;

   assign cnt_inc   = cnt + CNT_W'(1);
   assign last_word = (cnt == CNT_W'(DEPTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_PRIME;
         cnt       <= '0;
         rd_pend   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         state <= state_nx;
         if (state == S_COPY) begin
            cnt <= cnt_inc;
         end else if (state == S_PRIME) begin
            cnt <= '0;
         end
         if (state == S_RUN) begin
            // A simultaneous write wins: no read is registered, cpu_rdata keeps its value.
            rd_pend <= cpu_oe & ~cpu_we;
            if (rd_pend) begin
               cpu_rdata <= ram_rdata;
            end
         end else begin
            rd_pend <= 1'b0;
         end
      end
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      rom_addr  = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      cpu_hold  = 1'b1;
      init_done = 1'b0;
      unique case (state)
         S_PRIME: begin
            state_nx = S_COPY;
         end
         S_COPY: begin
            ram_we    = 1'b1;
            ram_addr  = WORD_W'(cnt[ROM_AW-1:0]);
            ram_wdata = rom_data;
            // Prefetch the next word; the wrap to 0 on the last word is never consumed.
            rom_addr  = cnt_inc[ROM_AW-1:0];
            if (last_word) begin
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            cpu_hold  = 1'b0;
            init_done = 1'b1;
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
         end
         default: begin
            state_nx = S_PRIME;
         end
      endcase
   end

endmodule

// File: tb/tb_slc3_mem_loader.sv
// Directed bench for slc3_mem_loader at DEPTH=4 with behavioural ROM/RAM and a scoreboard queue.
module tb_slc3_mem_loader;

   localparam int DEPTH  = 4;
   localparam int ROM_AW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [15:0]       cpu_addr, cpu_wdata, cpu_rdata;
   logic              cpu_oe, cpu_we, cpu_hold, init_done;
   logic [ROM_AW-1:0] rom_addr;
   logic [15:0]       rom_data, ram_addr, ram_wdata, ram_rdata;
   logic              ram_we;

   logic [15:0] rom_img [0:DEPTH-1];
   logic [15:0] ram [0:255];

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          passed = 0;
   int          total  = 0;
   logic [15:0] model_rdata;

   always #5 clk = ~clk;

   slc3_mem_loader #(.DEPTH(DEPTH), .ROM_AW(ROM_AW)) dut (
      .Clk       (clk),
      .Reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_oe    (cpu_oe),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_hold  (cpu_hold),
      .init_done (init_done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata)
   );

   always @(posedge clk) begin
      rom_data <= rom_img[rom_addr];
   end

   // NOTE: the RAM array is deliberately not reset; contents survive Reset like real memory.
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= ram[ram_addr[7:0]];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   // Advance to the next cycle; inputs are driven and outputs sampled 2 time units after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_hold"},  {31'd0, cpu_hold},  32'd1);
      check({pfx, "_done"},  {31'd0, init_done}, 32'd0);
      check({pfx, "_we"},    {31'd0, ram_we},    32'd0);
      check({pfx, "_rdata"}, {16'd0, cpu_rdata}, 32'd0);
   endtask

   // Starts in cycle 0 (S_PRIME); ends in cycle DEPTH+1 with S_RUN outputs checked.
   task automatic copy_phase(input string pfx);
      check({pfx, "_romaddr0"}, {30'd0, rom_addr}, 32'd0);
      check({pfx, "_ramaddr0"}, {16'd0, ram_addr}, 32'd0);
      check({pfx, "_wdata0"},   {16'd0, ram_wdata}, 32'd0);
      for (int k = 0; k < DEPTH; k++) begin
         push($sformatf("%s_copy%0d", pfx, k), {k[15:0], rom_img[k]});
         step();
         check($sformatf("%s_copy_we%0d", pfx, k), {31'd0, ram_we}, 32'd1);
         check($sformatf("%s_copy_hold%0d", pfx, k), {31'd0, cpu_hold}, 32'd1);
         pop_check({ram_addr, ram_wdata});
      end
      step();
      cpu_we    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_wdata = 16'h0000;
      #1;
      check({pfx, "_run_done"}, {31'd0, init_done}, 32'd1);
      check({pfx, "_run_hold"}, {31'd0, cpu_hold},  32'd0);
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [15:0] exp);
      cpu_oe   = 1'b1;
      cpu_addr = addr;
      push($sformatf("read_%04h", addr), {16'd0, exp});
      step();
      cpu_oe = 1'b0;
      #1;
      check($sformatf("read_%04h_early", addr), {16'd0, cpu_rdata}, {16'd0, model_rdata});
      step();
      pop_check({16'd0, cpu_rdata});
      model_rdata = exp;
      step();
      check($sformatf("read_%04h_held", addr), {16'd0, cpu_rdata}, {16'd0, model_rdata});
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input logic oe);
      cpu_we    = 1'b1;
      cpu_oe    = oe;
      cpu_addr  = addr;
      cpu_wdata = data;
      #1;
      check($sformatf("write_%04h_we", addr), {31'd0, ram_we}, 32'd1);
      check($sformatf("write_%04h_bus", addr), {ram_addr, ram_wdata}, {addr, data});
      step();
      cpu_we = 1'b0;
      cpu_oe = 1'b0;
   endtask

   initial begin
      rom_img[0] = 16'h1234;
      rom_img[1] = 16'h5678;
      rom_img[2] = 16'h9ABC;
      rom_img[3] = 16'hDEF0;
      reset       = 1'b1;
      cpu_oe      = 1'b0;
      cpu_addr    = 16'h0000;
      cpu_wdata   = 16'h0000;
      model_rdata = 16'h0000;
      // Core tries to overwrite RAM[0] throughout the first load; it must be ignored.
      cpu_we      = 1'b1;
      cpu_wdata   = 16'hFFFF;
      step();
      step();
      reset = 1'b0;
      #1;
      check_reset_outputs("rst1");
      copy_phase("load1");

      do_read(16'h0002, 16'h9ABC);
      do_read(16'h0000, 16'h1234);

      do_write(16'h0001, 16'hBEEF, 1'b0);
      do_read(16'h0001, 16'hBEEF);

      cpu_addr = 16'h0100;
      #1;
      check("passthru_addr", {16'd0, ram_addr}, 32'h0000_0100);
      check("passthru_we",   {31'd0, ram_we},   32'd0);
      step();

      do_write(16'h0003, 16'h0042, 1'b1);
      step();
      check("oe_we_rdata_hold", {16'd0, cpu_rdata}, {16'd0, model_rdata});
      do_read(16'h0003, 16'h0042);

      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      step();
      #1;
      check("midcopy_we", {31'd0, ram_we}, 32'd1);
      check("midcopy_addr", {16'd0, ram_addr}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      model_rdata = 16'h0000;
      check_reset_outputs("rst2");
      copy_phase("load2");
      for (int k = 0; k < DEPTH; k++) begin
         do_read(k[15:0], rom_img[k]);
      end

      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
